mem_bus_arbiter: RTL and testbench

- Shares the single byte-wide RAM/IO bus between two requesters: instruction fetch (IF) and the load/store buffer (LS).
- Serialises each 1/2/4-byte access into byte cycles and assembles or splits 32-bit words (little-endian).
- Applies round-robin grant, the UART back-pressure stall and speculative-read abort on rollback.
- Sits between the fetcher/LS buffer and the top-level mem_* ports.

---
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester byte-bus arbiter with little-endian word pack/unpack
module mem_bus_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [ADDR_LEN-1:0] mem_a,
  output logic                mem_wr,
  input  logic                io_buffer_full,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic                if_done,
  output logic [DATA_LEN-1:0] if_data,
  input  logic                ls_req,
  input  logic                ls_wr,
  input  logic [1:0]          ls_size,
  input  logic [ADDR_LEN-1:0] ls_addr,
  input  logic [DATA_LEN-1:0] ls_wdata,
  output logic                ls_done,
  output logic [DATA_LEN-1:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t              state, state_n;
  logic [2:0]          cnt, cnt_n, len;
  logic [ADDR_LEN-1:0] addr, cnt_a;
  logic [DATA_LEN-1:0] wdata, wshift, buf_q, buf_n;
  logic [DATA_LEN-1:0] if_data_q, ls_rdata_q;
  logic                last_ls, if_done_q, ls_done_q;
  logic                grant_if, grant_ls, fin_if, fin_ls, is_io, rd_busy;

  function automatic logic [2:0] len_of(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cnt_a   = ADDR_LEN'(cnt);
  assign is_io   = (addr[17:16] == 2'b11);
  assign rd_busy = (state == IF_RD) || (state == LS_RD);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    buf_n    = buf_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    fin_if   = 1'b0;
    fin_ls   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    wshift   = wdata >> {cnt[1:0], 3'b000};

    // mem_din carries the byte addressed in the previous busy cycle
    if (rd_busy) begin
      case (cnt)
        3'd1:    buf_n[7:0]   = mem_din;
        3'd2:    buf_n[15:8]  = mem_din;
        3'd3:    buf_n[23:16] = mem_din;
        3'd4:    buf_n[31:24] = mem_din;
        default: ;
      endcase
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rollback && !if_done_q && !ls_done_q) begin
          if (if_req && (!ls_req || last_ls)) grant_if = 1'b1;
          else if (ls_req)                    grant_ls = 1'b1;
        end
        if (grant_if)      state_n = IF_RD;
        else if (grant_ls) state_n = ls_wr ? LS_WR : LS_RD;
      end
      IF_RD, LS_RD: begin
        if (cnt != len) mem_a = addr + cnt_a;
        if (rollback) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == len) begin
          state_n = IDLE;
          cnt_n   = '0;
          fin_if  = (state == IF_RD);
          fin_ls  = (state == LS_RD);
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      LS_WR: begin
        // committed stores ignore rollback; only the UART stall holds them
        if (!(is_io && io_buffer_full)) begin
          mem_a    = addr + cnt_a;
          mem_dout = wshift[7:0];
          mem_wr   = 1'b1;
          if (cnt == len - 3'd1) begin
            state_n = IDLE;
            cnt_n   = '0;
            fin_ls  = 1'b1;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // while frozen, re-present the last read address so mem_din still holds that byte on resume
    if (!rdy) begin
      mem_wr   = 1'b0;
      mem_dout = '0;
      mem_a    = (rd_busy && cnt != 3'd0) ? addr + cnt_a - ADDR_LEN'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      addr       <= '0;
      wdata      <= '0;
      buf_q      <= '0;
      last_ls    <= 1'b1;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      state     <= state_n;
      cnt       <= cnt_n;
      buf_q     <= buf_n;
      if_done_q <= fin_if;
      ls_done_q <= fin_ls;
      if (fin_if)                     if_data_q  <= buf_n;
      if (fin_ls && state == LS_RD)   ls_rdata_q <= buf_n;
      if (grant_if) begin
        addr    <= if_addr;
        len     <= 3'd4;
        last_ls <= 1'b0;
        buf_q   <= '0;
      end
      if (grant_ls) begin
        addr    <= ls_addr;
        len     <= len_of(ls_size);
        wdata   <= ls_wdata;
        last_ls <= 1'b1;
        buf_q   <= '0;
      end
    end
  end

  assign if_done  = if_done_q & rdy;
  assign ls_done  = ls_done_q & rdy;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - bench for mem_bus_arbiter: vector table, hand traces, done/write scoreboards
module tb_mem_bus_arbiter;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
  logic [7:0]  mem_din = '0, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full = 1'b0;
  logic        if_req = 1'b0, if_done;
  logic [31:0] if_addr = '0, if_data;
  logic        ls_req = 1'b0, ls_wr = 1'b0, ls_done;
  logic [1:0]  ls_size = '0;
  logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;

  mem_bus_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          lat;   // edges from raising the request to seeing done; 0 = no done
    int          rb;    // cycle index carrying a rollback pulse, -1 = none
    int          rdy_e, rdy_n;
    int          io_e, io_n;
  } vec_t;

  typedef struct { int kind; logic [31:0] data; } exp_t;  // kind 0 IF, 1 load, 2 store
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  int          total = 0, bad = 0;
  logic [7:0]  ram [256];
  exp_t        sb [$];
  wr_t         wq [$];
  vec_t        vt [$];
  exp_t        e_pop;
  wr_t         w_pop;
  logic [31:0] last_ld = '0, last_if = '0;
  int          exp_a1 [6]  = '{0, 1, 2, 3, 0, 0};
  int          exp_a2 [13] = '{0, 1, 2, 3, 0, 0, 0, 'h100, 'h101, 'h102, 'h103, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit is_if, bit wr, logic [1:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] data, int lat, int rb = -1,
                              int rdy_e = -1, int rdy_n = 0, int io_e = -1, int io_n = 0);
    vec_t v;
    v.is_if = is_if; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.data = data; v.lat = lat; v.rb = rb; v.rdy_e = rdy_e; v.rdy_n = rdy_n;
    v.io_e = io_e; v.io_n = io_n;
    return v;
  endfunction

  function automatic bit win(int e, int s, int n);
    return (s >= 0) && (e >= s) && (e < s + n);
  endfunction

  // byte-wide RAM: data for an address appears one cycle later; writes are logged, not stored
  always @(posedge clk) mem_din <= ram[mem_a[7:0]];

  always @(negedge clk) begin
    if (!rst && (if_done || ls_done)) begin
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e_pop = sb.pop_front();
        check("done_src", {31'd0, if_done}, {31'd0, e_pop.kind == 0});
        if (e_pop.kind == 0)      check("if_data", if_data, e_pop.data);
        else if (e_pop.kind == 1) check("ls_rdata", ls_rdata, e_pop.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_wr) begin
      if (wq.size() == 0) check("unexpected_write", mem_a, 32'hFFFF_FFFF);
      else begin
        w_pop = wq.pop_front();
        check("wr_addr", mem_a, w_pop.a);
        check("wr_data", {24'd0, mem_dout}, {24'd0, w_pop.d});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    wr_t  w;
    int   n;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    if (v.lat == 0) return;
    e.kind = v.is_if ? 0 : (v.wr ? 2 : 1);
    e.data = v.data;
    sb.push_back(e);
    if (v.is_if) last_if = v.data;
    else if (!v.wr) last_ld = v.data;
    if (v.wr)
      for (int i = 0; i < n; i++) begin
        w.a = v.addr + 32'(i);
        w.d = 8'(v.wdata >> (8 * i));
        wq.push_back(w);
      end
  endtask

  // entered just after a posedge with the DUT idle and no done pending
  task automatic run_vec(input vec_t v);
    int lat = 0;
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      ls_req = 1'b1; ls_wr = v.wr; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
    end
    rollback       = (v.rb == 0);
    rdy            = !win(0, v.rdy_e, v.rdy_n);
    io_buffer_full = win(0, v.io_e, v.io_n);
    push_exp(v);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      rollback = (v.rb == e);
      if (v.rb == e && v.lat == 0) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
      rdy            = !win(e, v.rdy_e, v.rdy_n);
      io_buffer_full = win(e, v.io_e, v.io_n);
      @(negedge clk);
      if (!rdy) check("frozen_wr", {31'd0, mem_wr}, 32'd0);
      if (io_buffer_full && v.wr && v.addr[17:16] == 2'b11) check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
      if (v.lat != 0 && (v.is_if ? if_done : ls_done)) begin
        lat = e;
        break;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0; rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    check("latency", 32'(lat), 32'(v.lat));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 'h40);
    ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h01; ram[3] = 8'h00;

    vt.push_back(mk(1, 0, 2'd2, 32'h0,        32'h0,        32'h00010013, 6));
    vt.push_back(mk(0, 0, 2'd2, 32'h10,       32'h0,        32'h53525150, 6));
    vt.push_back(mk(0, 0, 2'd1, 32'h21,       32'h0,        32'h00006261, 4));
    vt.push_back(mk(0, 0, 2'd0, 32'hFF,       32'h0,        32'h0000003F, 3));
    vt.push_back(mk(0, 0, 2'd3, 32'h4,        32'h0,        32'h47464544, 6));
    vt.push_back(mk(0, 0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'h00133F3E, 6));
    vt.push_back(mk(0, 1, 2'd1, 32'h20,       32'h1234BEEF, 32'h0,        3));
    vt.push_back(mk(0, 1, 2'd0, 32'h7,        32'hFFFFFFA5, 32'h0,        2));
    vt.push_back(mk(0, 1, 2'd2, 32'hFFFFFFFF, 32'h11223344, 32'h0,        5));
    vt.push_back(mk(0, 1, 2'd2, 32'h40,       32'hCAFEF00D, 32'h0,        5, 2));
    vt.push_back(mk(1, 0, 2'd2, 32'h8,        32'h0,        32'h4B4A4948, 7, 0));
    vt.push_back(mk(0, 0, 2'd2, 32'h10,       32'h0,        32'h0,        0, 3));
    vt.push_back(mk(0, 0, 2'd0, 32'h5,        32'h0,        32'h0,        0, 2));
    vt.push_back(mk(1, 0, 2'd2, 32'h14,       32'h0,        32'h57565554, 6));
    vt.push_back(mk(1, 0, 2'd2, 32'h8,        32'h0,        32'h4B4A4948, 11, -1, 2, 5));
    vt.push_back(mk(0, 1, 2'd1, 32'h60,       32'h00009C3B, 32'h0,        6, -1, 1, 3));
    vt.push_back(mk(0, 1, 2'd0, 32'h30000,    32'h41,       32'h0,        5, -1, -1, 0, 1, 3));
    vt.push_back(mk(0, 1, 2'd0, 32'h20000,    32'h99,       32'h0,        2, -1, -1, 0, 0, 5));
    vt.push_back(mk(0, 0, 2'd0, 32'h30005,    32'h0,        32'h45,       3, -1, -1, 0, 0, 5));

    do_reset();
    @(negedge clk);
    check("rst_mem_a",    mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
    check("rst_if_done",  {31'd0, if_done}, 32'd0);
    check("rst_ls_done",  {31'd0, ls_done}, 32'd0);
    check("rst_if_data",  if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk); #1;

    // single fetch from 0: address trace and done timing
    if_req = 1'b1; if_addr = 32'h0;
    push_exp(mk(1, 0, 2'd2, 32'h0, 32'h0, 32'h00010013, 6));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_mem_a",   mem_a, 32'(exp_a1[i]));
      check("t1_mem_wr",  {31'd0, mem_wr}, 32'd0);
      check("t1_if_done", {31'd0, if_done}, {31'd0, i == 5});
    end
    @(posedge clk); #1;
    if_req = 1'b0;

    // simultaneous requests right after reset: IF first, then LS with no burst overlap
    do_reset();
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
    push_exp(mk(1, 0, 2'd2, 32'h0,   32'h0, 32'h00010013, 6));
    push_exp(mk(0, 0, 2'd2, 32'h100, 32'h0, 32'h00010013, 6));
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      if (i == 6) if_req = 1'b0;
      @(negedge clk);
      check("t2_mem_a",   mem_a, 32'(exp_a2[i]));
      check("t2_if_done", {31'd0, if_done}, {31'd0, i == 5});
      check("t2_ls_done", {31'd0, ls_done}, {31'd0, i == 12});
    end
    @(posedge clk); #1;
    ls_req = 1'b0;

    foreach (vt[k]) run_vec(vt[k]);

    check("if_data_hold",  if_data, last_if);
    check("ls_rdata_hold", ls_rdata, last_ld);
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("wq_drain", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
